// File: rtl/mult_div_unit_if.sv
// Operand/handshake/HI-LO bundle between pipeline control and the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_dat;
  logic [WIDTH-1:0] b_dat;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] w_dat;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a_dat, b_dat, hi_we, lo_we, w_dat,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a_dat, b_dat, hi_we, lo_we, w_dat,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding architectural HI/LO; one bit per cycle.
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU complete as no-ops.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic            clk,
  input logic            Rst,
  mult_div_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StFin, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;    // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;      // multiplier / dividend shifting into quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;  // |multiplicand| / |divisor|
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             neg_q, neg_d;

  logic             op_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

`ifdef MDU_DIV_EN
  logic             is_div_q, is_div_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;
  logic [WIDTH:0]   div_shift, div_diff;
  logic [WIDTH-1:0] quo_fix, rem_fix;
`endif

  always_comb begin
    op_signed = ~bus.op[0];
    a_neg     = op_signed & bus.a_dat[WIDTH-1];
    b_neg     = op_signed & bus.b_dat[WIDTH-1];
    a_abs     = a_neg ? -bus.a_dat : bus.a_dat;
    b_abs     = b_neg ? -bus.b_dat : bus.b_dat;
    mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    prod      = {acc_q, mq_q};
    prod_fix  = neg_q ? -prod : prod;
`ifdef MDU_DIV_EN
    div_shift = {acc_q, mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    // Divide by zero yields all-ones quotient; remainder already equals |A|.
    quo_fix   = dz_q ? {WIDTH{1'b1}} : (neg_q ? -mq_q : mq_q);
    rem_fix   = neg_rem_q ? -acc_q : acc_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    mq_d      = mq_q;
    opnd_d    = opnd_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
`ifdef MDU_DIV_EN
    is_div_d  = is_div_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
`endif

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.hi_we) hi_d = bus.w_dat;
        if (bus.lo_we) lo_d = bus.w_dat;
        state_d = StIdle;
        if (bus.start) begin
          cnt_d = '0;
          acc_d = '0;
          neg_d = a_neg ^ b_neg;
`ifdef MDU_DIV_EN
          is_div_d = bus.op[1];
          state_d  = StRun;
          if (bus.op[1]) begin
            opnd_d    = b_abs;
            mq_d      = a_abs;
            neg_rem_d = a_neg;
            dz_d      = (bus.b_dat == '0);
          end else begin
            opnd_d    = a_abs;
            mq_d      = b_abs;
            neg_rem_d = 1'b0;
            dz_d      = 1'b0;
          end
`else
          if (bus.op[1]) begin
            state_d = StDone;
          end else begin
            opnd_d  = a_abs;
            mq_d    = b_abs;
            state_d = StRun;
          end
`endif
        end
      end

      StRun: begin
        cnt_d = cnt_q + 1'b1;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_d = div_diff[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = div_shift[WIDTH-1:0];
            mq_d  = {mq_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_d = mul_sum[WIDTH:1];
          mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end
`else
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFin;
      end

      StFin: begin
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
`else
        hi_d = prod_fix[2*WIDTH-1:WIDTH];
        lo_d = prod_fix[WIDTH-1:0];
`endif
        state_d = StDone;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q  <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      mq_q      <= mq_d;
      opnd_q    <= opnd_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
`ifdef MDU_DIV_EN
      is_div_q  <= is_div_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun) || (state_q == StFin);
  assign bus.done = (state_q == StDone);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: vector table, random ops against an arithmetic model,
// and hand-written handshake/reset sequences. Tracks MDU_DIV_EN to pick expected divide behaviour.
module tb_mult_div_unit;
  localparam int unsigned W = 32;
`ifdef MDU_DIV_EN
  localparam bit DivEn = 1'b1;
`else
  localparam bit DivEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic Rst = 1'b1;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] hi_m, lo_m;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
  } vec_t;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Architectural result from plain arithmetic; cur is returned when the op is a no-op.
  function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [63:0] cur);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00:   r = 64'(sa * sb);
      2'b01:   r = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (!DivEn)     r = cur;
        else if (b == 0) r = {a, 32'hFFFF_FFFF};
        else            r = {32'(sa % sb), 32'(sa / sb)};
      end
      default: begin
        if (!DivEn)     r = cur;
        else if (b == 0) r = {a, 32'hFFFF_FFFF};
        else            r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] e[5];
    e = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(0, 3) == 0) return e[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  // Called at a negedge; returns just after the launch edge.
  task automatic drive_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic hw, input logic lw, input logic [31:0] wd);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a_dat = a;
    bus.b_dat = b;
    bus.hi_we = hw;
    bus.lo_we = lw;
    bus.w_dat = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
  endtask

  // Samples every cycle after launch; optionally pokes start/hi_we/lo_we mid-run.
  task automatic wait_result(input string nm, input int exp_busy, input logic [31:0] eh,
                             input logic [31:0] el, input logic [31:0] sh, input logic [31:0] sl,
                             input int inject_at, input bit tail);
    int nb = 0;
    bit seen = 1'b0;
    bit stable = 1'b1;
    bit injected = 1'b0;
    for (int c = 0; c < 80 && !seen; c++) begin
      @(negedge clk);
      if (injected) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        injected  = 1'b0;
      end
      if (bus.done) begin
        seen = 1'b1;
      end else if (bus.busy) begin
        if (bus.hi !== sh || bus.lo !== sl) stable = 1'b0;
        if (nb == inject_at) begin
          bus.start = 1'b1;
          bus.op    = 2'b01;
          bus.a_dat = 32'h1234;
          bus.b_dat = 32'h10;
          bus.hi_we = 1'b1;
          bus.lo_we = 1'b1;
          bus.w_dat = 32'hBAD0_BAD0;
          injected  = 1'b1;
        end
        nb++;
      end
    end
    check({nm, " done_seen"}, 64'(seen), 64'd1);
    check({nm, " busy_at_done"}, 64'(bus.busy), 64'd0);
    check({nm, " busy_cycles"}, 64'(nb), 64'(exp_busy));
    check({nm, " hilo_stable_while_busy"}, 64'(stable), 64'd1);
    check({nm, " hilo"}, {bus.hi, bus.lo}, {eh, el});
    if (tail) begin
      @(negedge clk);
      check({nm, " done_one_cycle"}, 64'(bus.done), 64'd0);
      check({nm, " hilo_held"}, {bus.hi, bus.lo}, {eh, el});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[9];
    logic [63:0] exp_r;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          eb;
    int          dones;
    bit          run_ok;

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a_dat = '0;
    bus.b_dat = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.w_dat = '0;

    repeat (2) @(negedge clk);
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    Rst  = 1'b0;
    hi_m = '0;
    lo_m = '0;

    // MTHI then MTLO while idle
    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.w_dat = 32'hA5A5_0001;
    @(posedge clk);
    #1 bus.hi_we = 1'b0;
    @(negedge clk);
    check("mthi idle", {bus.hi, bus.lo}, {32'hA5A5_0001, 32'h0});
    bus.lo_we = 1'b1;
    bus.w_dat = 32'h5A5A_0002;
    @(posedge clk);
    #1 bus.lo_we = 1'b0;
    @(negedge clk);
    check("mtlo idle", {bus.hi, bus.lo}, {32'hA5A5_0001, 32'h5A5A_0002});
    hi_m = 32'hA5A5_0001;
    lo_m = 32'h5A5A_0002;

    tbl[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    tbl[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    tbl[3] = '{2'b11, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF};
    tbl[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    tbl[5] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    tbl[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[7] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    tbl[8] = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};

    for (int i = 0; i < 9; i++) begin
      logic [31:0] eh, el;
      if (tbl[i].op[1] && !DivEn) begin
        eh = hi_m;
        el = lo_m;
        eb = 0;
      end else begin
        eh = tbl[i].eh;
        el = tbl[i].el;
        eb = 33;
      end
      drive_start(tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, 1'b0, 32'h0);
      wait_result($sformatf("vec%0d", i), eb, eh, el, hi_m, lo_m, -1, 1'b1);
      hi_m = eh;
      lo_m = el;
    end

    for (int i = 0; i < 40; i++) begin
      rop   = 2'($urandom_range(0, 3));
      ra    = pick();
      rb    = pick();
      exp_r = ref_op(rop, ra, rb, {hi_m, lo_m});
      eb    = (rop[1] && !DivEn) ? 0 : 33;
      drive_start(rop, ra, rb, 1'b0, 1'b0, 32'h0);
      wait_result($sformatf("rnd%0d op%0d a=%h b=%h", i, rop, ra, rb), eb,
                  exp_r[63:32], exp_r[31:0], hi_m, lo_m, -1, 1'b1);
      hi_m = exp_r[63:32];
      lo_m = exp_r[31:0];
    end

    // MTHI on the launch edge lands, then the product overwrites it
    drive_start(2'b01, 32'h10, 32'h20, 1'b1, 1'b0, 32'hDEAD_BEEF);
    wait_result("start_with_mthi", 33, 32'h0, 32'h200, 32'hDEAD_BEEF, lo_m, -1, 1'b1);
    hi_m = 32'h0;
    lo_m = 32'h200;

    // start/MTHI/MTLO while busy are ignored
    drive_start(2'b00, 32'hFFFF_FFFD, 32'h7, 1'b0, 1'b0, 32'h0);
    wait_result("busy_inject", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB, hi_m, lo_m, 4, 1'b1);
    hi_m = 32'hFFFF_FFFF;
    lo_m = 32'hFFFF_FFEB;

    // Relaunch straight from DONE
    drive_start(2'b01, 32'd3, 32'd4, 1'b0, 1'b0, 32'h0);
    wait_result("b2b_first", 33, 32'h0, 32'd12, hi_m, lo_m, -1, 1'b0);
    drive_start(2'b01, 32'd6, 32'd7, 1'b0, 1'b0, 32'h0);
    wait_result("b2b_second", 33, 32'h0, 32'd42, 32'h0, 32'd12, -1, 1'b1);
    hi_m = 32'h0;
    lo_m = 32'd42;

    // Reset mid-run aborts; nothing is written and done never pulses
    drive_start(2'b01, 32'd5, 32'd6, 1'b0, 1'b0, 32'h0);
    run_ok = 1'b1;
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      if (!bus.busy || bus.done || bus.hi !== hi_m || bus.lo !== lo_m) run_ok = 1'b0;
      if (c == 10) begin
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a_dat = 32'd7;
        bus.b_dat = 32'd9;
        bus.hi_we = 1'b1;
        bus.w_dat = 32'd1;
      end else if (c == 11) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b0;
      end
    end
    check("rst_seq pre_reset_run", 64'(run_ok), 64'd1);
    @(negedge clk);
    Rst = 1'b1;
    #1;
    check("rst_seq busy", 64'(bus.busy), 64'd0);
    check("rst_seq hilo", {bus.hi, bus.lo}, 64'd0);
    repeat (2) @(negedge clk);
    Rst  = 1'b0;
    hi_m = '0;
    lo_m = '0;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dones++;
    end
    check("rst_seq no_done_after", 64'(dones), 64'd0);
    drive_start(2'b01, 32'd5, 32'd6, 1'b0, 1'b0, 32'h0);
    wait_result("rst_seq relaunch", 33, 32'h0, 32'd30, 32'h0, 32'h0, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
